// File: rtl/traffic_cfg_pkg.sv
// Shared definitions for the traffic-light configuration path: menu state
// encoding, field indices and the default duration width. Used by the menu,
// the sequencer and the display blocks.
package traffic_cfg_pkg;

    // Default width of every duration value, in seconds
    localparam int TIME_W_DEF = 6;

    // Menu state encoding (kept as plain constants for legacy consumers)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_EDIT   = 2'd2;

    // Field index of each traffic-phase duration
    typedef logic [1:0] field_t;
    localparam field_t FIELD_GREEN  = 2'd0;
    localparam field_t FIELD_YELLOW = 2'd1;
    localparam field_t FIELD_ALLRED = 2'd2;
    localparam field_t FIELD_PED    = 2'd3;

    // Neighbouring field; the 2-bit index wraps naturally (3+1=0, 0-1=3)
    function automatic field_t field_step(input field_t f, input logic fwd);
        return fwd ? field_t'(f + 2'd1) : field_t'(f - 2'd1);
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles while enabled and flags expiry after TIMEOUT_CYCLES
// consecutive cycles with neither clear nor disable. A clear in the same
// cycle suppresses the expiry, so user activity always wins.
module inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("inactivity_timer: TIMEOUT_CYCLES must be at least 1");
    end

    logic [CNT_W-1:0] r_count;

    assign o_expire = i_enable && !i_clear && (r_count == LAST_CNT);

    // Idle-cycle counter: restarts on activity, when disabled and after expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear || !i_enable || o_expire) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + ONE_CNT;
        end
    end

endmodule

// File: rtl/timing_config_menu.sv
// Operator menu for viewing and editing the four traffic-phase durations.
// Owns the committed duration registers feeding the sequencer and drives the
// menu/field/value signals shown on the 7-segment display. All outputs are
// registered: a press seen at one edge is reflected after that edge.
module timing_config_menu
    import traffic_cfg_pkg::*;
#(
    parameter int          TIME_W         = TIME_W_DEF,
    parameter int          MIN_T          = 1,
    parameter int          MAX_T          = 60,
    parameter int          DEF_GREEN      = 20,
    parameter int          DEF_YELLOW     = 3,
    parameter int          DEF_ALLRED     = 2,
    parameter int          DEF_PED        = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up_pressed,
    input  logic              btn_down_pressed,
    input  logic              btn_left_pressed,
    input  logic              btn_right_pressed,
    input  logic              btn_center_pressed,
    output logic [TIME_W-1:0] t_green,
    output logic [TIME_W-1:0] t_yellow,
    output logic [TIME_W-1:0] t_allred,
    output logic [TIME_W-1:0] t_ped,
    output logic              cfg_update,
    output logic              menu_active,
    output logic              editing,
    output logic [1:0]        menu_field,
    output logic [TIME_W-1:0] edit_value
);

    if ((MAX_T >> TIME_W) != 0) begin : g_bad_max
        $error("timing_config_menu: MAX_T does not fit in TIME_W bits");
    end
    if (MIN_T > MAX_T) begin : g_bad_range
        $error("timing_config_menu: MIN_T exceeds MAX_T");
    end
    if (DEF_GREEN < MIN_T || DEF_GREEN > MAX_T || DEF_YELLOW < MIN_T || DEF_YELLOW > MAX_T ||
        DEF_ALLRED < MIN_T || DEF_ALLRED > MAX_T || DEF_PED < MIN_T || DEF_PED > MAX_T) begin : g_bad_def
        $error("timing_config_menu: a default duration lies outside [MIN_T, MAX_T]");
    end

    localparam logic [TIME_W-1:0] MIN_V = TIME_W'(MIN_T);
    localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_T);
    localparam logic [TIME_W-1:0] ONE_V = TIME_W'(1);

    // Saturating step: the limit is checked before the add so nothing wraps
    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
        if (v >= MAX_V) return MAX_V;
        return v + ONE_V;
    endfunction

    function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
        if (v <= MIN_V) return MIN_V;
        return v - ONE_V;
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_n;
    field_t            r_field;
    field_t            w_field_n;
    logic [TIME_W-1:0] r_edit_value;
    logic [TIME_W-1:0] w_edit_value_n;
    logic [TIME_W-1:0] w_work_n;
    logic [TIME_W-1:0] r_t [4];
    logic              w_commit;
    logic              r_cfg_update;
    logic              r_menu_active;
    logic              r_editing;
    logic              w_any_pulse;
    logic              w_expire;

    assign w_any_pulse = btn_up_pressed | btn_down_pressed | btn_left_pressed |
                         btn_right_pressed | btn_center_pressed;

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_any_pulse || (r_state == ST_IDLE)),
        .i_enable(r_state != ST_IDLE),
        .o_expire(w_expire)
    );

    // Next-state decode; in EDIT the displayed value register doubles as the working value
    always_comb begin
        w_state_n      = r_state;
        w_field_n      = r_field;
        w_work_n       = r_edit_value;
        w_commit       = 1'b0;
        w_edit_value_n = '0;
        case (r_state)
            ST_IDLE: begin
                if (btn_center_pressed) begin
                    w_state_n = ST_SELECT;
                    w_field_n = FIELD_GREEN;
                end
            end
            ST_SELECT: begin
                if (btn_center_pressed) begin
                    w_state_n = ST_EDIT;
                    w_work_n  = r_t[r_field];
                end else if (btn_left_pressed) begin
                    w_field_n = field_step(r_field, 1'b0);
                end else if (btn_right_pressed) begin
                    w_field_n = field_step(r_field, 1'b1);
                end else if (btn_up_pressed) begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_EDIT: begin
                if (btn_center_pressed) begin
                    w_commit  = 1'b1;
                    w_state_n = ST_SELECT;
                end else if (btn_left_pressed) begin
                    w_state_n = ST_SELECT;
                end else if (btn_up_pressed) begin
                    w_work_n = sat_inc(r_edit_value);
                end else if (btn_down_pressed) begin
                    w_work_n = sat_dec(r_edit_value);
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_expire) begin
            w_state_n = ST_IDLE;
        end
        case (w_state_n)
            ST_EDIT:   w_edit_value_n = w_work_n;
            ST_SELECT: w_edit_value_n = w_commit ? r_edit_value : r_t[w_field_n];
            default:   w_edit_value_n = '0;
        endcase
    end

    // Menu state and registered display/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_field       <= FIELD_GREEN;
            r_edit_value  <= '0;
            r_cfg_update  <= 1'b0;
            r_menu_active <= 1'b0;
            r_editing     <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_field       <= w_field_n;
            r_edit_value  <= w_edit_value_n;
            r_cfg_update  <= w_commit;
            r_menu_active <= (w_state_n != ST_IDLE);
            r_editing     <= (w_state_n == ST_EDIT);
        end
    end

    // Committed durations; a commit rewrites the field even if the value is unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_t[FIELD_GREEN]  <= TIME_W'(DEF_GREEN);
            r_t[FIELD_YELLOW] <= TIME_W'(DEF_YELLOW);
            r_t[FIELD_ALLRED] <= TIME_W'(DEF_ALLRED);
            r_t[FIELD_PED]    <= TIME_W'(DEF_PED);
        end else if (w_commit) begin
            r_t[r_field] <= r_edit_value;
        end
    end

    assign t_green     = r_t[FIELD_GREEN];
    assign t_yellow    = r_t[FIELD_YELLOW];
    assign t_allred    = r_t[FIELD_ALLRED];
    assign t_ped       = r_t[FIELD_PED];
    assign cfg_update  = r_cfg_update;
    assign menu_active = r_menu_active;
    assign editing     = r_editing;
    assign menu_field  = r_field;
    assign edit_value  = r_edit_value;

endmodule

// File: tb/tb_timing_config_menu.sv
// Self-checking bench for timing_config_menu: a directed vector table, hand
// sequences for saturation, timeout, simultaneous presses and async reset,
// then random single presses checked against a behavioural menu model.
module tb_timing_config_menu;

    localparam int TW  = 6;
    localparam int TMO = 16;

    // Button vectors packed as {center, left, right, up, down}
    localparam logic [4:0] B_N = 5'b00000;
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_center = 1'b0;
    logic [TW-1:0] t_green, t_yellow, t_allred, t_ped, edit_value;
    logic          cfg_update, menu_active, editing;
    logic [1:0]    menu_field;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: mode 0 idle, 1 choosing a field, 2 editing a copy
    int m_mode, m_field, m_work, m_cfg, m_quiet;
    int m_t [4];

    typedef struct {
        logic [4:0] btn;
        int act, ed, fld, ev, cfg, tyel, tped;
    } vec_t;
    vec_t tbl [14];

    timing_config_menu #(
        .TIME_W(TW), .MIN_T(1), .MAX_T(60),
        .DEF_GREEN(20), .DEF_YELLOW(3), .DEF_ALLRED(2), .DEF_PED(10),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_up_pressed    (btn_up),
        .btn_down_pressed  (btn_down),
        .btn_left_pressed  (btn_left),
        .btn_right_pressed (btn_right),
        .btn_center_pressed(btn_center),
        .t_green           (t_green),
        .t_yellow          (t_yellow),
        .t_allred          (t_allred),
        .t_ped             (t_ped),
        .cfg_update        (cfg_update),
        .menu_active       (menu_active),
        .editing           (editing),
        .menu_field        (menu_field),
        .edit_value        (edit_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_work = 0; m_cfg = 0; m_quiet = 0;
        m_t[0] = 20; m_t[1] = 3; m_t[2] = 2; m_t[3] = 10;
    endtask

    function automatic int model_ev();
        if (m_mode == 2) return m_work;
        if (m_mode == 1) return m_t[m_field];
        return 0;
    endfunction

    // One clock of menu behaviour, described by the operator-visible rules
    task automatic model_step(input logic [4:0] b);
        bit c, l, r, u, d, any;
        int old_mode;
        {c, l, r, u, d} = b;
        any      = |b;
        old_mode = m_mode;
        m_cfg    = 0;
        if (m_mode == 0) begin
            if (c) begin m_mode = 1; m_field = 0; end
        end else if (m_mode == 1) begin
            if (c)      begin m_mode = 2; m_work = m_t[m_field]; end
            else if (l) m_field = (m_field + 3) % 4;
            else if (r) m_field = (m_field + 1) % 4;
            else if (u) m_mode = 0;
        end else begin
            if (c)      begin m_t[m_field] = m_work; m_cfg = 1; m_mode = 1; end
            else if (l) m_mode = 1;
            else if (u) m_work = (m_work < 60) ? m_work + 1 : 60;
            else if (d) m_work = (m_work > 1) ? m_work - 1 : 1;
        end
        if (any || old_mode == 0) begin
            m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == TMO) begin
                m_mode  = 0;
                m_quiet = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".t_green"},     int'(t_green),     m_t[0]);
        chk({tag, ".t_yellow"},    int'(t_yellow),    m_t[1]);
        chk({tag, ".t_allred"},    int'(t_allred),    m_t[2]);
        chk({tag, ".t_ped"},       int'(t_ped),       m_t[3]);
        chk({tag, ".cfg_update"},  int'(cfg_update),  m_cfg);
        chk({tag, ".menu_active"}, int'(menu_active), int'(m_mode != 0));
        chk({tag, ".editing"},     int'(editing),     int'(m_mode == 2));
        chk({tag, ".menu_field"},  int'(menu_field),  m_field);
        chk({tag, ".edit_value"},  int'(edit_value),  model_ev());
    endtask

    // Present buttons for exactly one active edge, then sample 1 time unit later
    task automatic drive_edge(input logic [4:0] b);
        {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
        @(posedge clk);
        model_step(b);
        #1;
        {btn_center, btn_left, btn_right, btn_up, btn_down} = B_N;
    endtask

    task automatic step(input string tag, input logic [4:0] b);
        drive_edge(b);
        check_all(tag);
    endtask

    // Asynchronous reset: outputs must take reset values before any clock edge
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{B_C, 1, 0, 0, 20, 0, 3, 10};
        tbl[1]  = '{B_R, 1, 0, 1, 3,  0, 3, 10};
        tbl[2]  = '{B_C, 1, 1, 1, 3,  0, 3, 10};
        tbl[3]  = '{B_U, 1, 1, 1, 4,  0, 3, 10};
        tbl[4]  = '{B_U, 1, 1, 1, 5,  0, 3, 10};
        tbl[5]  = '{B_U, 1, 1, 1, 6,  0, 3, 10};
        tbl[6]  = '{B_C, 1, 0, 1, 6,  1, 6, 10};
        tbl[7]  = '{B_N, 1, 0, 1, 6,  0, 6, 10};
        tbl[8]  = '{B_L, 1, 0, 0, 20, 0, 6, 10};
        tbl[9]  = '{B_L, 1, 0, 3, 10, 0, 6, 10};
        tbl[10] = '{B_C, 1, 1, 3, 10, 0, 6, 10};
        tbl[11] = '{B_U, 1, 1, 3, 11, 0, 6, 10};
        tbl[12] = '{B_L, 1, 0, 3, 10, 0, 6, 10};
        tbl[13] = '{B_N, 1, 0, 3, 10, 0, 6, 10};

        // Reset, then a few idle cycles with defaults held and no activity
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("rst");
        for (int i = 0; i < 3; i++) step("idle", B_N);
        chk("rst.t_green", int'(t_green), 20);
        chk("rst.t_yellow", int'(t_yellow), 3);
        chk("rst.t_allred", int'(t_allred), 2);
        chk("rst.t_ped", int'(t_ped), 10);
        chk("rst.menu_active", int'(menu_active), 0);

        // Directed table: yellow edit/commit, field wrap, cancel
        for (int i = 0; i < 14; i++) begin
            drive_edge(tbl[i].btn);
            chk($sformatf("tbl%0d.menu_active", i), int'(menu_active), tbl[i].act);
            chk($sformatf("tbl%0d.editing", i),     int'(editing),     tbl[i].ed);
            chk($sformatf("tbl%0d.menu_field", i),  int'(menu_field),  tbl[i].fld);
            chk($sformatf("tbl%0d.edit_value", i),  int'(edit_value),  tbl[i].ev);
            chk($sformatf("tbl%0d.cfg_update", i),  int'(cfg_update),  tbl[i].cfg);
            chk($sformatf("tbl%0d.t_yellow", i),    int'(t_yellow),    tbl[i].tyel);
            chk($sformatf("tbl%0d.t_ped", i),       int'(t_ped),       tbl[i].tped);
        end

        // Saturation at both ends
        do_reset("sat.rst");
        step("sat", B_C);
        step("sat", B_C);
        for (int i = 0; i < 45; i++) step("sat.up", B_U);
        chk("sat.max", int'(edit_value), 60);
        step("sat", B_L);
        step("sat", B_R);
        step("sat", B_R);
        step("sat", B_C);
        for (int i = 0; i < 5; i++) step("sat.dn", B_D);
        chk("sat.min", int'(edit_value), 1);
        chk("sat.t_green", int'(t_green), 20);

        // Inactivity timeout discards a pending edit
        do_reset("tmo.rst");
        step("tmo", B_C);
        step("tmo", B_C);
        step("tmo", B_U);
        chk("tmo.work", int'(edit_value), 21);
        for (int i = 0; i < TMO - 1; i++) step("tmo.wait", B_N);
        chk("tmo.still_edit", int'(editing), 1);
        step("tmo.exp", B_N);
        chk("tmo.idle", int'(menu_active), 0);
        chk("tmo.t_green", int'(t_green), 20);

        // Same-cycle center+up commits only; reset mid-edit restores defaults
        do_reset("pri.rst");
        step("pri", B_C);
        step("pri", B_C);
        step("pri", B_U);
        step("pri.cu", B_C | B_U);
        chk("pri.cfg", int'(cfg_update), 1);
        chk("pri.t_green", int'(t_green), 21);
        chk("pri.editing", int'(editing), 0);
        step("pri", B_C);
        step("pri", B_U);
        #3;
        do_reset("midrst");
        chk("midrst.t_green", int'(t_green), 20);
        chk("midrst.editing", int'(editing), 0);

        // Random single presses with occasional long quiet runs
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                for (int k = 0; k < TMO + 1; k++) step("rnd.q", B_N);
            end else if (r < 35) begin
                step("rnd", B_N);
            end else begin
                step("rnd", 5'(1 << $urandom_range(0, 4)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
